// File: rtl/sweep_sequencer.sv
// Two-leg calibration sweep sequencer: HS leg, fixed gap, VS leg, then a DONE pulse.
// Outputs are registered from next state; a counter flag fall drops its enable on the same edge.
module sweep_sequencer #(
    parameter int TIMEOUT    = 64,
    parameter int TO_W       = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic START,
    input  logic ABORT,
    input  logic CNT_L,
    input  logic CNT_V,
    output logic HS,
    output logic VS,
    output logic BUSY,
    output logic DONE,
    output logic ERR
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] H_ARM = 3'd1;
    localparam logic [2:0] H_RUN = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] V_ARM = 3'd4;
    localparam logic [2:0] V_RUN = 3'd5;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [2:0]       state, state_nxt;
    logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic             err_nxt, done_nxt;
    logic             leg_done, leg_to;

    // Completion is checked before timeout so a flag fall on the limit edge still counts as success.
    assign leg_done = ((state == H_RUN) && !CNT_L) || ((state == V_RUN) && !CNT_V);
    assign leg_to   = (to_cnt == TO_W'(TIMEOUT - 2));

    always_comb begin
        state_nxt   = state;
        to_cnt_nxt  = to_cnt;
        gap_cnt_nxt = gap_cnt;
        err_nxt     = ERR;
        done_nxt    = 1'b0;
        if (ABORT) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state_nxt  = H_ARM;
                        err_nxt    = 1'b0;
                        to_cnt_nxt = '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state_nxt   = V_ARM;
                        to_cnt_nxt  = '0;
                        gap_cnt_nxt = '0;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 1'b1;
                    end
                end
                H_ARM, H_RUN, V_ARM, V_RUN: begin
                    if (leg_done) begin
                        if (state == H_RUN) begin
                            state_nxt   = GAP;
                            gap_cnt_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else if (leg_to) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end else begin
                        to_cnt_nxt = to_cnt + 1'b1;
                        if (state == H_ARM && CNT_L) state_nxt = H_RUN;
                        if (state == V_ARM && CNT_V) state_nxt = V_RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            to_cnt  <= '0;
            gap_cnt <= '0;
            HS      <= 1'b0;
            VS      <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            state   <= state_nxt;
            to_cnt  <= to_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            HS      <= (state_nxt == H_ARM) || (state_nxt == H_RUN);
            VS      <= (state_nxt == V_ARM) || (state_nxt == V_RUN);
            BUSY    <= (state_nxt != IDLE);
            DONE    <= done_nxt;
            ERR     <= err_nxt;
        end
    end

endmodule
